// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl: shares one FIFO write port among NUM_WR producers with a
// round-robin arbiter and drains the FIFO read port to a single valid/ready
// consumer. A 2-entry output buffer hides the FIFO's 1-cycle read latency.
module fifo_access_ctrl #(
  parameter int unsigned NUM_WR = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_req,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [NUM_WR-1:0]        wr_gnt,
  input  logic                     fifo_full,
  input  logic                     fifo_empty,
  output logic                     fifo_wr_cs,
  output logic                     fifo_wr_en,
  output logic [DATA_W-1:0]        fifo_data_in,
  output logic                     fifo_rd_cs,
  output logic                     fifo_rd_en,
  input  logic [DATA_W-1:0]        fifo_data_out,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int unsigned PTR_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned OCC_W  = 3;
  localparam int unsigned OB_MAX = 2;

  // ---------------------------------------------------------------------
  // Write side state
  // ---------------------------------------------------------------------
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  sel_idx;
  logic              sel_found;
  logic              wr_go;
  logic [NUM_WR-1:0] gnt_vec;
  logic [DATA_W-1:0] wr_word;

  // ---------------------------------------------------------------------
  // Read side state
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]  ob_cnt_q, ob_cnt_d;
  logic [DATA_W-1:0] ob0_q, ob0_d;
  logic [DATA_W-1:0] ob1_q, ob1_d;
  logic              inflight_q, inflight_d;
  logic              rd_valid_q, rd_valid_d;
  logic              pop;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occ_after_pop;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_WR; k++) begin
      int unsigned cand;
      cand = (32'(rr_ptr_q) + k) % NUM_WR;
      if (!sel_found && wr_req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(cand);
      end
    end
  end

  // Write grant is gated by reset and by the FIFO full flag.
  always_comb begin
    wr_go   = rst && !fifo_full && sel_found;
    gnt_vec = '0;
    if (wr_go) begin
      gnt_vec = NUM_WR'(1) << sel_idx;
    end
  end

  // Mux the granted requester's slice onto the FIFO write data (0 when idle).
  always_comb begin
    wr_word = '0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (gnt_vec[i]) begin
        wr_word = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pointer advances to the granted requester so it goes last next round.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (wr_go) begin
      rr_ptr_d = sel_idx;
    end
  end

  assign wr_gnt       = gnt_vec;
  assign fifo_wr_cs   = wr_go;
  assign fifo_wr_en   = wr_go;
  assign fifo_data_in = wr_word;

  // Read issue: only when the buffer plus in-flight word still has room
  // after this cycle's pop, so a returning word always has a slot.
  always_comb begin
    pop           = rd_valid_q && rd_ready;
    push          = inflight_q;
    occ_after_pop = OCC_W'(ob_cnt_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    issue         = rst && !fifo_empty && (occ_after_pop < OCC_W'(OB_MAX));
  end

  assign fifo_rd_cs = issue;
  assign fifo_rd_en = issue;

  // Output buffer next state: ob0 is the head, ob1 the second entry.
  always_comb begin
    ob_cnt_d   = ob_cnt_q;
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    inflight_d = issue;
    case ({push, pop})
      2'b10: begin
        if (ob_cnt_q == CNT_W'(0)) begin
          ob0_d    = fifo_data_out;
          ob_cnt_d = CNT_W'(1);
        end else if (ob_cnt_q == CNT_W'(1)) begin
          ob1_d    = fifo_data_out;
          ob_cnt_d = CNT_W'(2);
        end
      end
      2'b01: begin
        if (ob_cnt_q == CNT_W'(2)) begin
          ob0_d = ob1_q;
        end
        ob_cnt_d = ob_cnt_q - CNT_W'(1);
      end
      2'b11: begin
        if (ob_cnt_q == CNT_W'(1)) begin
          ob0_d = fifo_data_out;
        end else begin
          ob0_d = ob1_q;
          ob1_d = fifo_data_out;
        end
      end
      default: begin
      end
    endcase
    rd_valid_d = (ob_cnt_d != CNT_W'(0));
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = ob0_q;

  // State registers with synchronous active-low reset; an in-flight read
  // is dropped by clearing inflight_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q   <= PTR_W'(NUM_WR - 1);
      ob_cnt_q   <= '0;
      ob0_q      <= '0;
      ob1_q      <= '0;
      inflight_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      ob_cnt_q   <= ob_cnt_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
      inflight_q <= inflight_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule
